// File: rtl/bin_frame_buffer.sv
// bin_frame_buffer: folds a stream of (bin, magnitude) samples into per-bin
// maxima and publishes them to the display registers only on a vblank strobe,
// so bars never tear mid-frame.
// Build option: define PEAK_DECAY_EN to get peak-hold with linear decay
// (bars rise instantly, fall by DECAY_STEP per commit, floored at zero).
module bin_frame_buffer #(
  parameter  int NUM_BINS   = 16,
  parameter  int WIDTH      = 12,
  parameter  int DECAY_STEP = 64,
  localparam int BIN_W      = $clog2(NUM_BINS)
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_bin,
  input  logic [WIDTH-1:0] in_mag,
  input  logic             in_last,
  input  logic             frame_tick,
  output logic [WIDTH-1:0] bin_amplitudes [0:NUM_BINS-1],
  output logic             commit_done,
  output logic             frame_drop
);

  localparam logic [0:0]       ST_ACCUM   = 1'b0;
  localparam logic [0:0]       ST_COMMIT  = 1'b1;
  localparam logic [BIN_W-1:0] IDX_LAST   = BIN_W'(NUM_BINS - 1);
  localparam logic [BIN_W:0]   BIN_LIMIT  = (BIN_W + 1)'(NUM_BINS);

  // The decay amount must be representable in a magnitude word.
  generate
    if (DECAY_STEP < 0 || DECAY_STEP >= (2 ** WIDTH)) begin : g_bad_decay_step
      $error("bin_frame_buffer: DECAY_STEP does not fit in WIDTH bits");
    end
  endgenerate

  logic [0:0]       state_q, state_d;
  logic [BIN_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             commitDone_q, commitDone_d;
  logic             frameDrop_q, frameDrop_d;
  logic [WIDTH-1:0] work_q [0:NUM_BINS-1];
  logic [WIDTH-1:0] work_d [0:NUM_BINS-1];
  logic [WIDTH-1:0] amp_q  [0:NUM_BINS-1];
  logic [WIDTH-1:0] amp_d  [0:NUM_BINS-1];

  logic             sampleAccept;
  logic             binInRange;
  logic             lastAccept;
  logic [WIDTH-1:0] commitValue;

  assign in_ready       = (state_q == ST_ACCUM);
  assign sampleAccept   = in_valid && in_ready;
  assign binInRange     = ({1'b0, in_bin} < BIN_LIMIT);
  assign lastAccept     = sampleAccept && in_last;
  assign bin_amplitudes = amp_q;
  assign commit_done    = commitDone_q;
  assign frame_drop     = frameDrop_q;

`ifdef PEAK_DECAY_EN
  localparam logic [WIDTH-1:0] DECAY_W = WIDTH'(DECAY_STEP);
  logic [WIDTH-1:0] heldDecayed;

  // Value published for the bin under the commit pointer: fresh maximum or the decayed held bar, whichever is larger.
  always_comb begin
    heldDecayed = '0;
    if (amp_q[idx_q] >= DECAY_W) begin
      heldDecayed = amp_q[idx_q] - DECAY_W;
    end
    commitValue = (work_q[idx_q] > heldDecayed) ? work_q[idx_q] : heldDecayed;
  end
`else
  assign commitValue = work_q[idx_q];
`endif

  // Next-state logic: fold samples while accumulating, walk the bins one per cycle while committing.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    commitDone_d = 1'b0;
    frameDrop_d  = 1'b0;
    work_d       = work_q;
    amp_d        = amp_q;

    if (state_q == ST_ACCUM) begin
      if (sampleAccept && binInRange) begin
        if (in_mag > work_q[in_bin]) begin
          work_d[in_bin] = in_mag;
        end
      end
      if (lastAccept) begin
        pending_d = 1'b1;
        if (pending_q) begin
          frameDrop_d = 1'b1;
        end
      end
      if (frame_tick && (pending_q || lastAccept)) begin
        state_d = ST_COMMIT;
        idx_d   = '0;
      end
    end else begin
      amp_d[idx_q]  = commitValue;
      work_d[idx_q] = '0;
      if (idx_q == IDX_LAST) begin
        commitDone_d = 1'b1;
        pending_d    = 1'b0;
        state_d      = ST_ACCUM;
        idx_d        = '0;
      end else begin
        idx_d = idx_q + BIN_W'(1);
      end
    end
  end

  // State registers; reset also wipes any half-written display values.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      commitDone_q <= 1'b0;
      frameDrop_q  <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        work_q[i] <= '0;
        amp_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      commitDone_q <= commitDone_d;
      frameDrop_q  <= frameDrop_d;
      work_q       <= work_d;
      amp_q        <= amp_d;
    end
  end

endmodule
